// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: D-side write buffer and line-refill arbiter onto the memory channels (optional WB_BYPASS_EN)
module dmem_req_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int WB_DEPTH         = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_refill_req,
    input  logic [ADDR_WIDTH-1:0]       i_refill_addr,
    output logic                        o_refill_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_refill_line,
    input  logic                        i_store_valid,
    output logic                        o_store_ready,
    input  logic [ADDR_WIDTH-1:0]       i_store_addr,
    input  logic [DATA_WIDTH-1:0]       i_store_data,
    input  logic [7:0]                  i_store_strobe,
    output logic                        o_wb_empty,
    output logic                        o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
    input  logic                        i_mem_read_done,
    input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
    output logic                        o_mem_write_valid,
    output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
    output logic [DATA_WIDTH-1:0]       o_mem_write_data,
    output logic [7:0]                  o_write_strobe,
    input  logic                        i_mem_write_done
);
    localparam int LOFF = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);
    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;
    state_t r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_fifo_addr [WB_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [WB_DEPTH];
    logic [7:0]            r_fifo_strb [WB_DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_push, w_pop, w_refill_ok, w_unused;
    assign o_store_ready = r_count != FULL;
    assign o_wb_empty    = (r_count == '0) & (r_state != WR);
    assign w_push        = i_store_valid & o_store_ready;
    assign w_pop         = (r_state == WR) & i_mem_write_done;
    assign w_unused      = ^i_refill_addr[LOFF-1:0];
`ifdef WB_BYPASS_EN
    logic [WB_DEPTH-1:0] w_hit;
    for (genvar i = 0; i < WB_DEPTH; i++) begin : g_hit
        logic [PW-1:0] w_off;
        assign w_off    = PW'(i) - r_rptr;
        assign w_hit[i] = ({1'b0, w_off} < r_count) &
                          (r_fifo_addr[i][ADDR_WIDTH-1:LOFF] == i_refill_addr[ADDR_WIDTH-1:LOFF]);
    end
    assign w_refill_ok = ~|w_hit;
`else
    assign w_refill_ok = r_count == '0;
`endif
    // next state: refill wins ties when it is safe w.r.t. buffered stores
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (i_refill_req & w_refill_ok) ? RD : (r_count != '0) ? WR : IDLE;
            WR:      w_next = i_mem_write_done ? IDLE : WR;
            RD:      w_next = i_mem_read_done ? RESP : RD;
            default: w_next = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    // write-buffer pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_push);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    // write-buffer storage needs no reset: occupancy gates every read
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= i_store_addr;
            r_fifo_data[r_wptr] <= i_store_data;
            r_fifo_strb[r_wptr] <= i_store_strobe;
        end
    end
    // registered memory-side and cache-side outputs, loaded on state entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_read_req      <= 1'b0;
            o_mem_write_valid   <= 1'b0;
            o_refill_done       <= 1'b0;
            o_mem_read_address  <= '0;
            o_mem_write_address <= '0;
            o_mem_write_data    <= '0;
            o_write_strobe      <= '0;
            o_refill_line       <= '0;
        end else begin
            o_mem_read_req    <= w_next == RD;
            o_mem_write_valid <= w_next == WR;
            o_refill_done     <= w_next == RESP;
            if (r_state == IDLE && w_next == RD)
                o_mem_read_address <= {i_refill_addr[ADDR_WIDTH-1:LOFF], {LOFF{1'b0}}};
            if (r_state == IDLE && w_next == WR) begin
                o_mem_write_address <= r_fifo_addr[r_rptr];
                o_mem_write_data    <= r_fifo_data[r_rptr];
                o_write_strobe      <= r_fifo_strb[r_rptr];
            end
            if (r_state == RD && i_mem_read_done)
                o_refill_line <= i_cache_line;
        end
    end
endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl: scoreboard bench for dmem_req_ctrl (honours WB_BYPASS_EN)
module tb_dmem_req_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic         i_refill_req = 1'b0;
    logic [31:0]  i_refill_addr = '0;
    logic         o_refill_done;
    logic [255:0] o_refill_line;
    logic         i_store_valid = 1'b0;
    logic         o_store_ready;
    logic [31:0]  i_store_addr = '0;
    logic [31:0]  i_store_data = '0;
    logic [7:0]   i_store_strobe = '0;
    logic         o_wb_empty;
    logic         o_mem_read_req;
    logic [31:0]  o_mem_read_address;
    logic         i_mem_read_done = 1'b0;
    logic [255:0] i_cache_line = '0;
    logic         o_mem_write_valid;
    logic [31:0]  o_mem_write_address;
    logic [31:0]  o_mem_write_data;
    logic [7:0]   o_write_strobe;
    logic         i_mem_write_done = 1'b0;

    dmem_req_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_refill_req(i_refill_req), .i_refill_addr(i_refill_addr),
        .o_refill_done(o_refill_done), .o_refill_line(o_refill_line),
        .i_store_valid(i_store_valid), .o_store_ready(o_store_ready),
        .i_store_addr(i_store_addr), .i_store_data(i_store_data),
        .i_store_strobe(i_store_strobe), .o_wb_empty(o_wb_empty),
        .o_mem_read_req(o_mem_read_req), .o_mem_read_address(o_mem_read_address),
        .i_mem_read_done(i_mem_read_done), .i_cache_line(i_cache_line),
        .o_mem_write_valid(o_mem_write_valid), .o_mem_write_address(o_mem_write_address),
        .o_mem_write_data(o_mem_write_data), .o_write_strobe(o_write_strobe),
        .i_mem_write_done(i_mem_write_done)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
    } txn_t;
    txn_t         exp_q[$];
    logic [255:0] line_q[$];
    int n_cmp = 0, n_err = 0, cyc = 0;
    int wlat = 2, rlat = 4, wdone_cyc = 0;
    bit hold_w = 1'b0;
    logic [255:0] mem_line = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        txn_t t;
        t.is_rd = 1'b0; t.addr = a; t.data = d; t.strb = s;
        exp_q.push_back(t);
    endtask

    task automatic push_r(input logic [31:0] a);
        txn_t t;
        t.is_rd = 1'b1; t.addr = {a[31:5], 5'b0}; t.data = '0; t.strb = '0;
        exp_q.push_back(t);
    endtask

    // memory responder: completes each transaction a fixed number of cycles after it appears
    initial begin
        int wc = 0, rc = 0;
        forever begin
            @(negedge clk);
            i_mem_write_done = 1'b0;
            i_mem_read_done  = 1'b0;
            if (o_mem_write_valid && !hold_w) begin
                wc++;
                if (wc >= wlat) begin i_mem_write_done = 1'b1; wc = 0; wdone_cyc = cyc; end
            end else wc = 0;
            if (o_mem_read_req) begin
                rc++;
                if (rc >= rlat) begin i_mem_read_done = 1'b1; i_cache_line = mem_line; rc = 0; end
            end else rc = 0;
        end
    end

    // monitor: every new memory transaction and every refill response is checked against the scoreboard
    initial begin
        bit pw = 1'b0, pr = 1'b0;
        txn_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_mem_write_valid && !pw) begin
                    if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("txn_kind_w", 0, 256'(e.is_rd));
                        chk("write_addr", 256'(o_mem_write_address), 256'(e.addr));
                        chk("write_data", 256'(o_mem_write_data), 256'(e.data));
                        chk("write_strobe", 256'(o_write_strobe), 256'(e.strb));
                    end
                end
                if (o_mem_read_req && !pr) begin
                    if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("txn_kind_r", 1, 256'(e.is_rd));
                        chk("read_addr", 256'(o_mem_read_address), 256'(e.addr));
                    end
                end
                if (o_refill_done) begin
                    if (line_q.size() == 0) chk("unexpected_refill_done", 1, 0);
                    else chk("refill_line", o_refill_line, line_q.pop_front());
                end
            end
            pw = o_mem_write_valid;
            pr = o_mem_read_req;
        end
    end

    task automatic wait_refill_done(input string nm);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_refill_done) return;
        end
        chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_wb_empty && !o_mem_read_req && !o_refill_done) return;
        end
        chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic store1(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        i_store_valid = 1'b1; i_store_addr = a; i_store_data = d; i_store_strobe = s;
        @(negedge clk);
        i_store_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ready"}, 256'(o_store_ready), 1);
        chk({nm, "_wb_empty"}, 256'(o_wb_empty), 1);
        chk({nm, "_read_req"}, 256'(o_mem_read_req), 0);
        chk({nm, "_write_valid"}, 256'(o_mem_write_valid), 0);
        chk({nm, "_refill_done"}, 256'(o_refill_done), 0);
        chk({nm, "_refill_line"}, o_refill_line, 0);
        chk({nm, "_read_addr"}, 256'(o_mem_read_address), 0);
        chk({nm, "_write_addr"}, 256'({o_mem_write_address, o_mem_write_data, o_write_strobe}), 0);
    endtask

    initial begin
        int t0;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        // T1: reset in the middle of a refill read abandons it
        rlat = 10;
        push_r(32'h0000_0040);
        i_refill_req = 1'b1; i_refill_addr = 32'h0000_0040;
        repeat (3) @(negedge clk);
        chk("t1_read_req_before_reset", 256'(o_mem_read_req), 1);
        rst_n = 1'b0;
        i_refill_req = 1'b0;
        @(negedge clk);
        chk_reset_outs("t1_in_reset");
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("t1_no_read_after", 256'(o_mem_read_req), 0);
        // T2: refill latency and line alignment
        rlat = 4;
        mem_line = {32{8'hA5}};
        push_r(32'h0000_1234);
        line_q.push_back({32{8'hA5}});
        i_refill_req = 1'b1; i_refill_addr = 32'h0000_1234;
        t0 = cyc;
        wait_refill_done("t2_refill");
        chk("t2_latency", 256'(cyc - t0), 5);
        i_refill_req = 1'b0;
        @(negedge clk);
        chk("t2_done_single_pulse", 256'(o_refill_done), 0);
        // T3: fill the buffer with write completions withheld
        hold_w = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_w(32'h0000_3000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 8'h0F);
            i_store_valid = 1'b1; i_store_addr = 32'h0000_3000 + 32'(i * 4);
            i_store_data = 32'hC0DE_0000 + 32'(i); i_store_strobe = 8'h0F;
            chk($sformatf("t3_ready_%0d", i), 256'(o_store_ready), (i < 4) ? 1 : 0);
            if (i < 4) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("t3_ready_still_full", 256'(o_store_ready), 0);
        hold_w = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                seen = o_store_ready;
            end
            chk("t3_ready_returns", 256'(seen), 1);
            chk("t3_ready_one_after_done", 256'(cyc - wdone_cyc), 1);
        end
        @(negedge clk);
        i_store_valid = 1'b0;
        wait_empty("t3_drain");
        // T4: FIFO order and strobe pass-through
        push_w(32'h0000_0A00, 32'hAAAA_0001, 8'h01);
        push_w(32'h0000_0B04, 32'hBBBB_0002, 8'h03);
        push_w(32'h0000_0C08, 32'hCCCC_0003, 8'h0F);
        store1(32'h0000_0A00, 32'hAAAA_0001, 8'h01);
        store1(32'h0000_0B04, 32'hBBBB_0002, 8'h03);
        store1(32'h0000_0C08, 32'hCCCC_0003, 8'h0F);
        wait_empty("t4_drain");
        chk("t4_all_written", 256'(exp_q.size()), 0);
        chk("t4_wb_empty", 256'(o_wb_empty), 1);
        // T5: read-after-write to the same line drains the store first
        mem_line = {8{32'h1111_2222}};
        push_w(32'h0000_0100, 32'h5555_0100, 8'h0F);
        push_r(32'h0000_0104);
        line_q.push_back({8{32'h1111_2222}});
        store1(32'h0000_0100, 32'h5555_0100, 8'h0F);
        i_refill_req = 1'b1; i_refill_addr = 32'h0000_0104;
        wait_refill_done("t5_refill");
        i_refill_req = 1'b0;
        wait_empty("t5_drain");
        chk("t5_order", 256'(exp_q.size()), 0);
        // T6: refill to an unrelated line
        mem_line = {4{64'h0123_4567_89AB_CDEF}};
`ifdef WB_BYPASS_EN
        push_r(32'h0000_0404);
        push_w(32'h0000_0200, 32'h6666_0200, 8'h03);
`else
        push_w(32'h0000_0200, 32'h6666_0200, 8'h03);
        push_r(32'h0000_0404);
`endif
        line_q.push_back({4{64'h0123_4567_89AB_CDEF}});
        store1(32'h0000_0200, 32'h6666_0200, 8'h03);
        i_refill_req = 1'b1; i_refill_addr = 32'h0000_0404;
        wait_refill_done("t6_refill");
        i_refill_req = 1'b0;
        wait_empty("t6_drain");
        repeat (4) @(negedge clk);
        chk("final_txn_queue", 256'(exp_q.size()), 0);
        chk("final_line_queue", 256'(line_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
